// File: rtl/lbist_lfsr_engine_if.sv
// lbist_lfsr_engine_if: BIST controller <-> LFSR engine bus
// master drives: start, seed_load, seed_in, mode, pat_count, misr_in
// slave drives: q, busy, done, signature, lockup
interface lbist_lfsr_engine_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic             seed_load;
   logic             mode;
   logic             busy;
   logic             done;
   logic             lockup;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] misr_in;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] signature;
   logic [CNT_W-1:0] pat_count;
   modport master (
      output start, seed_load, seed_in, mode, pat_count, misr_in,
      input  q, busy, done, signature, lockup
   );
   modport slave (
      input  start, seed_load, seed_in, mode, pat_count, misr_in,
      output q, busy, done, signature, lockup
   );
endinterface

// File: rtl/lbist_lfsr_engine.sv
// lbist_lfsr_engine: Fibonacci LFSR pattern generator / MISR compactor with run control
// ports: clk, reset (sync, active-high), bus (slave modport of lbist_lfsr_engine_if)
module lbist_lfsr_engine #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
   parameter logic [WIDTH-1:0] SEED_RST = '1,
   parameter int               CNT_W    = 16
) (
   input logic clk,
   input logic reset,
   lbist_lfsr_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic             fb;
   logic             go;
   logic             ld;
   logic             mode_eff;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] q_next;
   always_comb begin
      fb       = ^(bus.q & TAPS);
      step     = {bus.q[WIDTH-2:0], fb} ^ (mode_q ? bus.misr_in : '0);
      ld       = state == IDLE && bus.seed_load;
      go       = state == IDLE && bus.start;
      q_next   = state == RUN ? step : ld ? bus.seed_in : bus.q;
      // IDLE follows the live mode input; RUN/DONE use the mode latched at start
      mode_eff = state == IDLE ? bus.mode : mode_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.q         <= SEED_RST;
         bus.signature <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.lockup    <= 1'b0;
         cnt           <= '0;
         mode_q        <= 1'b0;
         state         <= IDLE;
      end else begin
         bus.q      <= q_next;
         bus.lockup <= q_next == '0 && !mode_eff;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         case (state)
            IDLE: if (go) begin
               mode_q <= bus.mode;
               cnt    <= bus.pat_count;
               if (bus.pat_count == '0) begin
                  // zero-length run: signature is the (possibly just loaded) seed
                  state         <= DONE;
                  bus.done      <= 1'b1;
                  bus.signature <= q_next;
               end else begin
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state         <= DONE;
                  bus.done      <= 1'b1;
                  bus.signature <= step;
               end else begin
                  bus.busy <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lbist_lfsr_engine.sv
// tb_lbist_lfsr_engine: directed + randomized checks of lbist_lfsr_engine against a bit-count model
module tb_lbist_lfsr_engine;
   localparam logic [7:0] TAPS = 8'hB8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q = 8'hFF;
   logic [7:0] exp_sig = 8'h00;
   logic [7:0] hist[$];
   logic [7:0] mq[$];
   lbist_lfsr_engine_if #(.WIDTH(8), .CNT_W(16)) bus ();
   lbist_lfsr_engine #(.WIDTH(8), .TAPS(8'hB8), .SEED_RST(8'hFF), .CNT_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // feedback parity taken by counting tapped ones, shift done arithmetically
   function automatic logic [7:0] nxt(input logic [7:0] s, input logic m, input logic [7:0] d);
      int c;
      int v;
      c = 0;
      for (int i = 0; i < 8; i++) if (s[i] && TAPS[i]) c++;
      v = (int'(s) * 2 + c % 2) % 256;
      return 8'(v) ^ (m ? d : 8'h00);
   endfunction
   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
      end
   endtask
   task automatic chk1(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask
   task automatic chki(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input logic ld, input logic [7:0] sd, input logic m);
      bus.start = 1'b0;
      bus.seed_load = ld;
      bus.seed_in = sd;
      bus.mode = m;
      tick();
      bus.seed_load = 1'b0;
      if (ld) exp_q = sd;
      chk8("idle_q", bus.q, exp_q);
      chk1("idle_lock", bus.lockup, exp_q == 8'h00 && !m);
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_done", bus.done, 1'b0);
   endtask
   task automatic run(input logic ld, input logic [7:0] sd, input logic m, input int n, input logic junk);
      logic [7:0] d;
      bus.start = 1'b1;
      bus.seed_load = ld;
      bus.seed_in = sd;
      bus.mode = m;
      bus.pat_count = 16'(n);
      if (ld) exp_q = sd;
      tick();
      bus.start = 1'b0;
      bus.seed_load = 1'b0;
      hist.delete();
      if (n == 0) begin
         exp_sig = exp_q;
         chk1("zero_done", bus.done, 1'b1);
         chk1("zero_busy", bus.busy, 1'b0);
         chk8("zero_sig", bus.signature, exp_sig);
         chk8("zero_q", bus.q, exp_q);
         chk1("zero_lock", bus.lockup, exp_q == 8'h00 && !m);
      end else begin
         chk1("start_busy", bus.busy, 1'b1);
         chk1("start_done", bus.done, 1'b0);
         chk8("start_q", bus.q, exp_q);
      end
      for (int k = 1; k <= n; k++) begin
         d = mq.size() != 0 ? mq.pop_front() : 8'($urandom);
         bus.misr_in = d;
         if (junk) begin
            bus.start = 1'($urandom);
            bus.seed_load = 1'($urandom);
            bus.seed_in = 8'($urandom);
            bus.mode = 1'($urandom);
         end
         tick();
         exp_q = nxt(exp_q, m, d);
         hist.push_back(bus.q);
         chk8("run_q", bus.q, exp_q);
         chk1("run_lock", bus.lockup, exp_q == 8'h00 && !m);
         chk1("run_busy", bus.busy, k < n);
         chk1("run_done", bus.done, k == n);
      end
      if (n > 0) begin
         exp_sig = exp_q;
         chk8("run_sig", bus.signature, exp_sig);
      end
      bus.start = 1'b0;
      bus.seed_load = 1'b0;
      bus.mode = m;
      tick();
      chk1("post_done", bus.done, 1'b0);
      chk1("post_busy", bus.busy, 1'b0);
      chk8("post_q", bus.q, exp_q);
      chk8("post_sig", bus.signature, exp_sig);
   endtask
   initial begin
      logic [7:0] t1[5];
      bit seen[256];
      int distinct;
      logic [7:0] d;
      t1 = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
      bus.start = 1'b0;
      bus.seed_load = 1'b0;
      bus.seed_in = 8'h00;
      bus.mode = 1'b0;
      bus.pat_count = 16'd0;
      bus.misr_in = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      chk8("rst_q", bus.q, 8'hFF);
      chk8("rst_sig", bus.signature, 8'h00);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_lock", bus.lockup, 1'b0);
      run(1'b0, 8'h00, 1'b0, 5, 1'b0);
      chki("t1_len", hist.size(), 5);
      for (int i = 0; i < 5; i++) chk8("t1_seq", hist[i], t1[i]);
      chk8("t1_sig", bus.signature, 8'hE1);
      run(1'b1, 8'h01, 1'b0, 255, 1'b0);
      distinct = 0;
      foreach (hist[i]) seen[hist[i]] = 1'b1;
      for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
      chki("t2_distinct", distinct, 255);
      chk1("t2_zero_seen", seen[0], 1'b0);
      chk8("t2_sig", bus.signature, 8'h01);
      idle(1'b1, 8'h00, 1'b1);
      mq = '{8'h01, 8'h80};
      run(1'b0, 8'h00, 1'b1, 2, 1'b0);
      chk8("t3_q1", hist[0], 8'h01);
      chk8("t3_q2", hist[1], 8'h82);
      chk8("t3_sig", bus.signature, 8'h82);
      chk1("t3_lock", bus.lockup, 1'b0);
      idle(1'b1, 8'h00, 1'b0);
      chk1("t4_lock", bus.lockup, 1'b1);
      run(1'b0, 8'h00, 1'b0, 3, 1'b0);
      chk8("t4_sig", bus.signature, 8'h00);
      chk8("t4_q", bus.q, 8'h00);
      idle(1'b1, 8'hA5, 1'b0);
      chk1("t4_unlock", bus.lockup, 1'b0);
      bus.start = 1'b1;
      bus.mode = 1'b0;
      bus.pat_count = 16'd100;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom);
         bus.misr_in = d;
         bus.start = 1'($urandom);
         bus.seed_load = 1'($urandom);
         bus.seed_in = 8'($urandom);
         bus.mode = 1'($urandom);
         tick();
         exp_q = nxt(exp_q, 1'b0, d);
         chk8("t5_q", bus.q, exp_q);
         chk1("t5_busy", bus.busy, 1'b1);
      end
      bus.start = 1'b0;
      bus.seed_load = 1'b0;
      bus.mode = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q = 8'hFF;
      exp_sig = 8'h00;
      chk8("t5_rst_q", bus.q, 8'hFF);
      chk1("t5_rst_busy", bus.busy, 1'b0);
      chk1("t5_rst_done", bus.done, 1'b0);
      chk8("t5_rst_sig", bus.signature, 8'h00);
      for (int k = 0; k < 3; k++) idle(1'b0, 8'h00, 1'b0);
      idle(1'b1, 8'h3C, 1'b0);
      run(1'b0, 8'h00, 1'b0, 0, 1'b0);
      chk8("t6_sig", bus.signature, 8'h3C);
      chk8("t6_q", bus.q, 8'h3C);
      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 1) == 1) idle(1'($urandom), 8'($urandom), 1'($urandom));
         run(1'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 30)), 1'b1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
